adc_serial_tx: RTL and testbench

ADC_SERIAL_TX -- requirements
Module: adc_serial_tx

---
 rtl/adc_serial_tx_if.sv | 28 ++
 rtl/adc_serial_tx.sv | 123 ++++++++++++
 tb/tb_adc_serial_tx.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_serial_tx_if.sv
// FWFT source FIFO port and serial frame outputs of the ADC serial transmitter.
// The master side is the transmitter; the slave side is the FIFO/receiver.
interface adc_serial_tx_if #(
    parameter int NCH   = 3,
    parameter int WIDTH = 16
);
    logic                   fifo_empty;
    logic [NCH*WIDTH-1:0]   fifo_dout;
    logic                   fifo_rd_en;
    logic                   valid_o;
    logic [NCH-1:0]         ch_data_o;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        output fifo_rd_en,
        output valid_o,
        output ch_data_o
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        input  fifo_rd_en,
        input  valid_o,
        input  ch_data_o
    );
endinterface

// File: rtl/adc_serial_tx.sv
// Pops NCH-lane words from a FWFT FIFO and shifts them out MSB first, one bit per
// lane per cycle, with an optional idle gap between words.
//
// state | meaning
// IDLE  | waiting for enable with a word available
// SHIFT | frame on the wire, bit_cnt = bits still to follow the current one
// GAP   | valid_o held low for the sampled number of gap cycles
module adc_serial_tx #(
    parameter int NCH   = 3,
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [7:0]          gap_cycles,
    adc_serial_tx_if.master     bus,
    output logic                busy,
    output logic [31:0]         word_cnt,
    output logic [15:0]         underrun_cnt
);
    localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t                 state, state_nxt;
    logic [NCH*WIDTH-1:0]   shreg;
    logic [BCW-1:0]         bit_cnt;
    logic [7:0]             gap_cnt;
    logic                   pop;
    logic                   underrun;
    logic                   last_bit;
    logic [NCH-1:0]         dout_msb;
    logic [NCH-1:0]         sh_msb;

    assign last_bit       = (state == SHIFT) && (bit_cnt == '0);
    assign busy           = (state != IDLE);
    assign bus.fifo_rd_en = pop & rst_n;

    always_comb begin
        dout_msb = '0;
        sh_msb   = '0;
        for (int i = 0; i < NCH; i++) begin
            dout_msb[i] = bus.fifo_dout[WIDTH*i + WIDTH-1];
            sh_msb[i]   = shreg[WIDTH*i + WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // enable takes priority at the end of a word so a disabled block never counts an underrun
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        underrun  = 1'b0;
        case (state)
            IDLE: begin
                if (enable && !bus.fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt == '0) begin
                    if (!enable) begin
                        state_nxt = IDLE;
                    end else if (gap_cycles != 8'd0) begin
                        state_nxt = GAP;
                    end else if (!bus.fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        underrun  = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_cnt <= 8'd1) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg         <= '0;
            bit_cnt       <= '0;
            gap_cnt       <= '0;
            bus.valid_o   <= 1'b0;
            bus.ch_data_o <= '0;
            word_cnt      <= '0;
            underrun_cnt  <= '0;
        end else begin
            if (pop) begin
                shreg         <= bus.fifo_dout << 1;
                bus.ch_data_o <= dout_msb;
                bus.valid_o   <= 1'b1;
                bit_cnt       <= BCW'(WIDTH-1);
            end else if (state == SHIFT && bit_cnt != '0) begin
                shreg         <= shreg << 1;
                bus.ch_data_o <= sh_msb;
                bit_cnt       <= bit_cnt - 1'b1;
            end else begin
                bus.valid_o   <= 1'b0;
                bus.ch_data_o <= '0;
            end

            // count as the final bit is driven, so the count is current during the last-bit cycle
            if ((pop && WIDTH == 1) || (state == SHIFT && bit_cnt == BCW'(1)))
                word_cnt <= word_cnt + 32'd1;

            if (last_bit && state_nxt == GAP)
                gap_cnt <= gap_cycles;
            else if (state == GAP)
                gap_cnt <= gap_cnt - 8'd1;

            if (underrun && underrun_cnt != 16'hFFFF)
                underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_adc_serial_tx.sv
// Directed and randomized bench for adc_serial_tx: a queue-based FWFT source, a
// frame reassembler on the serial lanes, and counter models checked against the DUT.
module tb_adc_serial_tx;
    localparam int NCH   = 3;
    localparam int WIDTH = 16;
    localparam int W     = NCH*WIDTH;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  gap_cycles = 8'd0;
    logic        busy;
    logic [31:0] word_cnt;
    logic [15:0] underrun_cnt;

    adc_serial_tx_if #(.NCH(NCH), .WIDTH(WIDTH)) bus ();

    adc_serial_tx #(.NCH(NCH), .WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .gap_cycles   (gap_cycles),
        .bus          (bus),
        .busy         (busy),
        .word_cnt     (word_cnt),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // source FIFO contents and words popped but not yet seen on the lanes
    logic [W-1:0] src_q[$];
    logic [W-1:0] exp_q[$];
    bit           pop_pending = 1'b0;
    int           pops = 0;

    initial begin
        bus.fifo_empty = 1'b1;
        bus.fifo_dout  = '0;
    end

    always @(posedge clk) begin
        #1;
        if (pop_pending && src_q.size() > 0) begin
            exp_q.push_back(src_q.pop_front());
            pops++;
        end
        bus.fifo_empty = (src_q.size() == 0);
        bus.fifo_dout  = (src_q.size() > 0) ? src_q[0] : '0;
    end

    logic [WIDTH-1:0] acc [NCH];
    logic [W-1:0]     word;
    int nbits = 0, recv = 0, valid_total = 0;
    int valid_run = 0, max_valid_run = 0, inval_run = 0, last_gap_run = 0;
    int exp_underrun = 0;
    bit saw_valid = 1'b0;

    always @(negedge clk) begin
        pop_pending = bus.fifo_rd_en;
        if (pop_pending)
            check("rd_en_while_empty", bus.fifo_empty, 0);
        if (!rst_n) begin
            check("rd_en_in_reset", bus.fifo_rd_en, 0);
            nbits = 0; recv = 0; exp_underrun = 0;
            valid_run = 0; inval_run = 0; saw_valid = 1'b0;
            exp_q.delete();
        end else if (bus.valid_o) begin
            if (saw_valid && inval_run > 0) last_gap_run = inval_run;
            inval_run = 0;
            saw_valid = 1'b1;
            valid_run++;
            valid_total++;
            if (valid_run > max_valid_run) max_valid_run = valid_run;
            for (int i = 0; i < NCH; i++) acc[i] = {acc[i][WIDTH-2:0], bus.ch_data_o[i]};
            nbits++;
            if (nbits == WIDTH) begin
                nbits = 0;
                recv++;
                for (int i = 0; i < NCH; i++) word[WIDTH*i +: WIDTH] = acc[i];
                check("frame_has_pop", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("frame_data", word, exp_q.pop_front());
                check("word_cnt_at_last_bit", word_cnt, recv);
                if (enable && gap_cycles == 8'd0 && bus.fifo_empty && exp_underrun < 65535)
                    exp_underrun++;
            end
        end else begin
            check("frame_truncated", nbits, 0);
            check("ch_zero_when_invalid", bus.ch_data_o, 0);
            valid_run = 0;
            inval_run++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_quiet(input string tag, input int budget);
        int n = 0;
        while ((busy || bus.valid_o || (enable && src_q.size() != 0)) && n < budget) begin
            step(1);
            n++;
        end
        if (n >= budget)
            check({"timeout_", tag}, {busy, bus.valid_o, src_q.size() != 0}, 0);
        step(1);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!bus.valid_o && n < budget) begin
            step(1);
            n++;
        end
        if (n >= budget) check({"timeout_", tag}, bus.valid_o, 1);
    endtask

    task automatic clear_stats();
        valid_total = 0; max_valid_run = 0; last_gap_run = 0; pops = 0;
    endtask

    int base_words, base_under;

    initial begin
        step(2);
        check("reset_valid", bus.valid_o, 0);
        check("reset_ch", bus.ch_data_o, 0);
        check("reset_busy", busy, 0);
        check("reset_word_cnt", word_cnt, 0);
        check("reset_underrun", underrun_cnt, 0);

        // single word; held in reset with a word available to prove the pop is blocked
        src_q.push_back(48'h0003_0002_0001);
        enable = 1'b1;
        step(2);
        check("rd_en_gated_by_reset", bus.fifo_rd_en, 0);
        clear_stats();
        rst_n = 1'b1;
        wait_quiet("single", 200);
        check("single_pops", pops, 1);
        check("single_valid_cycles", valid_total, 16);
        check("single_word_cnt", word_cnt, 1);
        check("single_underrun", underrun_cnt, 1);
        check("single_underrun_model", underrun_cnt, exp_underrun);

        // four words back to back, no gap
        clear_stats();
        base_words = word_cnt; base_under = underrun_cnt;
        for (int i = 0; i < 4; i++) src_q.push_back({16'hA000 + 16'(i), 16'h5A5A ^ 16'(i), 16'h8001 << i});
        wait_quiet("b2b", 400);
        check("b2b_contiguous", max_valid_run, 64);
        check("b2b_pops", pops, 4);
        check("b2b_words", word_cnt - base_words, 4);
        check("b2b_underrun", underrun_cnt - base_under, 1);

        // gap of 5, gap_cycles changed while the gap runs
        clear_stats();
        base_words = word_cnt; base_under = underrun_cnt;
        gap_cycles = 8'd5;
        src_q.push_back(48'hFFFF_0000_1234);
        src_q.push_back(48'h0F0F_F0F0_8000);
        step(20);
        gap_cycles = 8'd9;
        wait_quiet("gap", 400);
        check("gap_idle_cycles", last_gap_run, 6);
        check("gap_valid_cycles", valid_total, 32);
        check("gap_words", word_cnt - base_words, 2);
        check("gap_underrun", underrun_cnt - base_under, 0);

        // enable dropped at bit 3 of the first word
        clear_stats();
        base_words = word_cnt; base_under = underrun_cnt;
        gap_cycles = 8'd0;
        src_q.push_back(48'h1357_9BDF_2468);
        src_q.push_back(48'hC0DE_CAFE_BEEF);
        src_q.push_back(48'h0001_8000_7FFE);
        wait_valid("endrop", 20);
        step(3);
        enable = 1'b0;
        wait_quiet("endrop", 200);
        check("endrop_valid_cycles", valid_total, 16);
        check("endrop_pops", pops, 1);
        check("endrop_words", word_cnt - base_words, 1);
        check("endrop_busy", busy, 0);
        check("endrop_underrun", underrun_cnt - base_under, 0);

        // reset at bit 8; the next queued word must follow from its MSB
        enable = 1'b1;
        wait_valid("rst_mid", 20);
        step(7);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_valid", bus.valid_o, 0);
        check("rst_mid_ch", bus.ch_data_o, 0);
        check("rst_mid_word_cnt", word_cnt, 0);
        check("rst_mid_underrun", underrun_cnt, 0);
        check("rst_mid_busy", busy, 0);
        step(2);
        clear_stats();
        rst_n = 1'b1;
        wait_quiet("rst_mid", 200);
        check("rst_mid_pops", pops, 1);
        check("rst_mid_words", word_cnt, 1);
        check("rst_mid_underrun_after", underrun_cnt, exp_underrun);

        // randomized loopback through the reassembler
        clear_stats();
        base_words = word_cnt;
        for (int i = 0; i < 1000; i++) begin
            src_q.push_back({$urandom(), $urandom()} & {W{1'b1}});
            if ($urandom_range(0, 3) == 0) gap_cycles = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                enable = 1'b0;
                step($urandom_range(1, 20));
                enable = 1'b1;
            end
            if ($urandom_range(0, 15) == 0) step(40);
            else step($urandom_range(0, 12));
        end
        enable = 1'b1;
        wait_quiet("random", 60000);
        check("random_pops", pops, 1000);
        check("random_words", word_cnt - base_words, 1000);
        check("random_recv", recv - base_words, 1000);
        check("random_leftover", exp_q.size(), 0);
        check("random_underrun", underrun_cnt, exp_underrun);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
